dma_bus_arbiter: RTL and testbench
==================================

Name: dma_bus_arbiter

Overview:
- Owns the system memory bus and grants it to three masters: the CPU (default owner), the DSP DMA channel and the blitter.
- Obtains the bus from the CPU with a HOLD/HLDA handshake.
- Drives DSPBAK/DSPBAKL into the DSP DMA memory-cycle sequencer.
- Lets a DSP request pre-empt a running blitter tenure, then resumes the blitter before returning the bus to the CPU.

Parameters:
- TURN_CYCLES, default 1: idle cycles inserted between two bus owners (range 1..15).
- CNT_W, default 4: width of the turnaround counter.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- RESETL  in  1  asynchronous active-low reset.
- DSPBRQ  in  1  DSP DMA bus request, level; held until the DMA cycle has finished.
- BLTBRQ  in  1  blitter bus request, level; dropped when finished or when yielding.
- HLDA  in  1  CPU hold acknowledge.
- HOLD  out  1  hold request to the CPU.
- DSPBAK  out  1  DSP bus acknowledge.
- DSPBAKL  out  1  inverse of DSPBAK.
- BLTBAK  out  1  blitter bus acknowledge.
- BLTHOLD  out  1  asks the blitter to yield at its next safe point.
- BUSTURN  out  1  high during turnaround cycles; no master owns the bus.

Behaviour:
- Reset: one clock (CLK) and an asynchronous, active-low reset (RESETL).
- Values in reset: state S_CPU; HOLD=0, DSPBAK=0, DSPBAKL=1, BLTBAK=0, BLTHOLD=0, BUSTURN=0; suspend flag=0; counter=0.
- Reset asserted mid-tenure clears all of the above immediately.
- All outputs are registered and decoded from the state (Moore).
- States:
  - S_CPU: HOLD=0. Leaves only when HLDA=0 and (DSPBRQ or BLTBRQ) -> S_HOLD. HLDA still high from a previous tenure blocks the exit.
  - S_HOLD: HOLD=1. On HLDA=1:
    - DSPBRQ -> S_DSP;
    - else BLTBRQ -> S_BLT;
    - else (request withdrawn) -> S_TURN.
  - S_DSP: HOLD=1, DSPBAK=1. When DSPBRQ=0 -> S_TURN.
  - S_BLT: HOLD=1, BLTBAK=1; clears the suspend flag on entry.
    - DSPBRQ=1 -> S_YIELD (DSP has priority).
    - else BLTBRQ=0 -> S_TURN.
  - S_YIELD: HOLD=1, BLTBAK=1, BLTHOLD=1. When BLTBRQ=0 -> S_TURN and set the suspend flag.
  - S_TURN: HOLD=1, BUSTURN=1. Counter loads TURN_CYCLES-1 on entry and decrements. At 0:
    - DSPBRQ -> S_DSP;
    - else BLTBRQ and suspend=1 -> S_BLT;
    - else -> S_CPU, clearing suspend.
- Latency:
  - Request sampled in S_CPU at edge n: HOLD=1 after edge n.
  - HLDA sampled at edge m: grant output high after edge m.
  - Grant drops on the edge that samples the request low.
- Simultaneous DSPBRQ and BLTBRQ in S_HOLD or S_TURN: DSP wins.
- A blitter that requests again after a normal finish does not bypass the CPU; it re-enters through S_CPU.
- DSPBRQ falling in S_YIELD before the blitter yields: stay in S_YIELD until BLTBRQ=0, then S_TURN decides.
- HLDA falling while HOLD=1 outside S_HOLD is a protocol violation. The state machine ignores it; the verification assertion flags it.
- At most one of DSPBAK and BLTBAK is ever high, and neither is high while BUSTURN=1 (invariant).

Decomposition:
- Shared package holds:
  - arb_state_t enum: S_CPU, S_HOLD, S_DSP, S_BLT, S_YIELD, S_TURN;
  - the TURN_CYCLES default constant.
- Sub-module turn_counter: loadable down-counter with a zero flag, CNT_W wide.
- Everything else sits in one always_ff block plus an output decode.

Test Plan:
- Reset, then DSPBRQ=1 at cycle 2, HLDA=1 at cycle 4 -> HOLD=1 from cycle 3, DSPBAK=1/DSPBAKL=0 from cycle 5. Drop DSPBRQ at 9 -> DSPBAK=0 at 10, BUSTURN=1 for one cycle, HOLD=0 at 11.
- BLTBRQ=1 with HLDA answering in 2 cycles, BLTBRQ held for 20 cycles -> BLTBAK high for exactly 20 cycles, then one turnaround, then HOLD=0.
- Blitter granted; DSPBRQ=1 at cycle 10 -> BLTHOLD=1 at 11. Blitter drops BLTBRQ at 14, reasserts at 16 -> DSPBAK at 16. DSP done at 20 -> BLTBAK again after the turnaround, without dropping HOLD.
- DSPBRQ and BLTBRQ both rise in the same cycle -> DSPBAK granted first; BLTBAK follows only after a CPU tenure (suspend=0).
- TURN_CYCLES=3 -> BUSTURN high exactly 3 cycles between owners. HLDA held high after HOLD drops -> no new HOLD until HLDA=0.
- RESETL pulsed low during S_YIELD -> all outputs at reset values within the same cycle; normal operation after release.

Source files
------------

// File: rtl/dma_bus_arbiter_pkg.sv
// Shared types and constants for the DMA bus arbiter.
package dma_bus_arbiter_pkg;

  // Bus ownership / arbitration phases.
  typedef enum logic [2:0] {
    S_CPU   = 3'd0,
    S_HOLD  = 3'd1,
    S_DSP   = 3'd2,
    S_BLT   = 3'd3,
    S_YIELD = 3'd4,
    S_TURN  = 3'd5
  } arb_state_t;

  localparam int TURN_CYCLES_DEF = 1;
  localparam int CNT_W_DEF       = 4;

  // Output bundle driven by the arbiter; DSPBAKL is derived from dspbak.
  typedef struct packed {
    logic hold;
    logic dspbak;
    logic bltbak;
    logic blthold;
    logic busturn;
  } arb_out_t;

  // Moore decode: every output is a pure function of the state.
  function automatic arb_out_t decode_outputs(arb_state_t s);
    arb_out_t o;
    o = '0;
    case (s)
      S_CPU:   o = '0;
      S_HOLD:  o.hold = 1'b1;
      S_DSP:   begin o.hold = 1'b1; o.dspbak = 1'b1; end
      S_BLT:   begin o.hold = 1'b1; o.bltbak = 1'b1; end
      S_YIELD: begin o.hold = 1'b1; o.bltbak = 1'b1; o.blthold = 1'b1; end
      S_TURN:  begin o.hold = 1'b1; o.busturn = 1'b1; end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/dma_bus_arbiter_if.sv
// Request / acknowledge signals between the arbiter, the CPU and the DMA masters.
// Handshake: each requester holds its *BRQ level until it has finished (or, for
// the blitter, until it yields); the arbiter answers with a level *BAK that stays
// high for the whole tenure and drops on the edge that samples the request low.
// HOLD/HLDA follow the same level protocol towards the CPU.
interface dma_bus_arbiter_if;
  logic DSPBRQ;
  logic BLTBRQ;
  logic HLDA;
  logic HOLD;
  logic DSPBAK;
  logic DSPBAKL;
  logic BLTBAK;
  logic BLTHOLD;
  logic BUSTURN;

  // Arbiter side: drives hold and acknowledges.
  modport master (
    input  DSPBRQ, BLTBRQ, HLDA,
    output HOLD, DSPBAK, DSPBAKL, BLTBAK, BLTHOLD, BUSTURN
  );

  // Requester / CPU side.
  modport slave (
    output DSPBRQ, BLTBRQ, HLDA,
    input  HOLD, DSPBAK, DSPBAKL, BLTBAK, BLTHOLD, BUSTURN
  );
endinterface

// File: rtl/dma_bus_arbiter_turn_counter.sv
// Loadable down-counter that times the idle gap between two bus owners.
module dma_bus_arbiter_turn_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q;

  // Load has priority over decrement; decrement saturates at zero.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/dma_bus_arbiter.sv
// Memory bus arbiter: CPU is the default owner, DSP DMA and blitter borrow the
// bus through HOLD/HLDA. A DSP request pre-empts the blitter, which is resumed
// after the DSP tenure without handing the bus back to the CPU in between.
module dma_bus_arbiter
  import dma_bus_arbiter_pkg::*;
#(
  parameter int TURN_CYCLES = TURN_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                  CLK,
  input  logic                  RESETL,
  dma_bus_arbiter_if.master     bus,
  output arb_state_t            dbg_state_o
);

  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);

  arb_state_t state_q, state_d;
  arb_out_t   out_q;
  logic       suspend_q, suspend_d;
  logic       cnt_load, cnt_dec, cnt_zero;

  // Next-state and suspend-flag logic.
  always_comb begin
    state_d   = state_q;
    suspend_d = suspend_q;
    case (state_q)
      S_CPU: begin
        // A lingering HLDA from the previous tenure must clear first.
        if (!bus.HLDA && (bus.DSPBRQ || bus.BLTBRQ)) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (bus.HLDA) begin
          if (bus.DSPBRQ)      state_d = S_DSP;
          else if (bus.BLTBRQ) state_d = S_BLT;
          else                 state_d = S_TURN;
        end
      end
      S_DSP: begin
        if (!bus.DSPBRQ) state_d = S_TURN;
      end
      S_BLT: begin
        suspend_d = 1'b0;
        if (bus.DSPBRQ)       state_d = S_YIELD;
        else if (!bus.BLTBRQ) state_d = S_TURN;
      end
      S_YIELD: begin
        // Wait for the blitter to reach a safe point even if the DSP gives up.
        if (!bus.BLTBRQ) begin
          state_d   = S_TURN;
          suspend_d = 1'b1;
        end
      end
      S_TURN: begin
        if (cnt_zero) begin
          if (bus.DSPBRQ) begin
            state_d = S_DSP;
          end else if (bus.BLTBRQ && suspend_q) begin
            state_d = S_BLT;
          end else begin
            state_d   = S_CPU;
            suspend_d = 1'b0;
          end
        end
      end
      default: begin
        state_d   = S_CPU;
        suspend_d = 1'b0;
      end
    endcase
  end

  // Counter loads on entry to S_TURN and counts down while there.
  assign cnt_load = (state_d == S_TURN) && (state_q != S_TURN);
  assign cnt_dec  = (state_q == S_TURN) && !cnt_zero;

  dma_bus_arbiter_turn_counter #(
    .CNT_W (CNT_W)
  ) u_turn_counter (
    .clk_i      (CLK),
    .rst_n_i    (RESETL),
    .load_i     (cnt_load),
    .load_val_i (TURN_LOAD),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // State register with outputs registered from the next-state decode.
  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      state_q   <= S_CPU;
      suspend_q <= 1'b0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      suspend_q <= suspend_d;
      out_q     <= decode_outputs(state_d);
    end
  end

  assign bus.HOLD    = out_q.hold;
  assign bus.DSPBAK  = out_q.dspbak;
  assign bus.DSPBAKL = ~out_q.dspbak;
  assign bus.BLTBAK  = out_q.bltbak;
  assign bus.BLTHOLD = out_q.blthold;
  assign bus.BUSTURN = out_q.busturn;

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter: per-cycle expected output vectors are
// queued as stimulus is driven and checked one cycle later.
module tb_dma_bus_arbiter;
  import dma_bus_arbiter_pkg::*;

  // Output vector order: {HOLD, DSPBAK, DSPBAKL, BLTBAK, BLTHOLD, BUSTURN}
  localparam logic [5:0] O_CPU = 6'b001000;
  localparam logic [5:0] O_HLD = 6'b101000;
  localparam logic [5:0] O_DSP = 6'b110000;
  localparam logic [5:0] O_BLT = 6'b101100;
  localparam logic [5:0] O_YLD = 6'b101110;
  localparam logic [5:0] O_TRN = 6'b101001;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_l = 1'b1;
  always #5 clk = ~clk;

  logic dsp = 1'b0, blt = 1'b0, hlda = 1'b0;
  logic use3 = 1'b0;

  dma_bus_arbiter_if bus1 ();
  dma_bus_arbiter_if bus3 ();
  arb_state_t st1, st3;

  assign bus1.DSPBRQ = dsp;
  assign bus1.BLTBRQ = blt;
  assign bus1.HLDA   = hlda;
  assign bus3.DSPBRQ = dsp;
  assign bus3.BLTBRQ = blt;
  assign bus3.HLDA   = hlda;

  dma_bus_arbiter #(.TURN_CYCLES(1), .CNT_W(4)) dut1 (
    .CLK(clk), .RESETL(rst_l), .bus(bus1), .dbg_state_o(st1)
  );

  dma_bus_arbiter #(.TURN_CYCLES(3), .CNT_W(4)) dut3 (
    .CLK(clk), .RESETL(rst_l), .bus(bus3), .dbg_state_o(st3)
  );

  // Scoreboard
  logic [5:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int blt_hi = 0;
  int trn_hi = 0;
  string tag = "reset";
  int step_no = 0;

  function automatic logic [5:0] obs();
    if (use3)
      return {bus3.HOLD, bus3.DSPBAK, bus3.DSPBAKL, bus3.BLTBAK, bus3.BLTHOLD, bus3.BUSTURN};
    else
      return {bus1.HOLD, bus1.DSPBAK, bus1.DSPBAKL, bus1.BLTBAK, bus1.BLTHOLD, bus1.BUSTURN};
  endfunction

  task automatic check_out();
    logic [5:0] e, o;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s/%0d scoreboard empty obs=%b exp=none", tag, step_no, obs());
    end else begin
      e = exp_q.pop_front();
      o = obs();
      n_cmp++;
      assert (o === e) else begin
        n_err++;
        $error("FAIL %s/%0d outputs obs=%b exp=%b", tag, step_no, o, e);
      end
      n_cmp++;
      assert (!(o[4] && o[2]) && !(o[0] && (o[4] || o[2]))) else begin
        n_err++;
        $error("FAIL %s/%0d grant_invariant obs=%b exp=exclusive", tag, step_no, o);
      end
      if (o[2]) blt_hi++;
      if (o[0]) trn_hi++;
    end
    step_no++;
  endtask

  // Drive one cycle of inputs and check the outputs after the next edge.
  task automatic cyc(input logic d, input logic b, input logic h, input logic [5:0] e);
    dsp = d; blt = b; hlda = h;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic apply_reset();
    dsp = 1'b0; blt = 1'b0; hlda = 1'b0;
    rst_l = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_l = 1'b1;
  endtask

  // HLDA must stay high for the whole tenure once the arbiter owns the bus.
  always @(negedge clk) begin
    if (rst_l && !hlda &&
        ((use3 ? st3 : st1) inside {S_DSP, S_BLT, S_YIELD, S_TURN})) begin
      n_err++;
      $error("FAIL hlda_protocol HLDA=%b exp=1 while bus borrowed", hlda);
    end
  end

  initial begin
    // Reset state
    #2 rst_l = 1'b0;
    #1;
    tag = "reset"; step_no = 0;
    exp_q.push_back(O_CPU);
    check_out();
    n_cmp++;
    assert (st1 === S_CPU) else begin
      n_err++;
      $error("FAIL reset_state obs=%0d exp=%0d", st1, S_CPU);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst_l = 1'b1;

    // DSP tenure with TURN_CYCLES=1
    tag = "dsp_basic"; step_no = 0;
    cyc(0, 0, 0, O_CPU);
    cyc(1, 0, 0, O_HLD);
    cyc(1, 0, 0, O_HLD);
    cyc(1, 0, 1, O_DSP);
    repeat (4) cyc(1, 0, 1, O_DSP);
    cyc(0, 0, 1, O_TRN);
    cyc(0, 0, 1, O_CPU);
    cyc(0, 0, 0, O_CPU);

    // Blitter tenure of exactly 20 granted cycles
    tag = "blt_20"; step_no = 0;
    blt_hi = 0;
    cyc(0, 1, 0, O_HLD);
    cyc(0, 1, 0, O_HLD);
    cyc(0, 1, 1, O_BLT);
    repeat (19) cyc(0, 1, 1, O_BLT);
    cyc(0, 0, 1, O_TRN);
    cyc(0, 0, 1, O_CPU);
    cyc(0, 0, 0, O_CPU);
    n_cmp++;
    assert (blt_hi == 20) else begin
      n_err++;
      $error("FAIL blt_20_len obs=%0d exp=20", blt_hi);
    end

    // DSP pre-empts blitter, blitter resumes without losing HOLD
    tag = "preempt"; step_no = 0;
    cyc(0, 1, 0, O_HLD);
    cyc(0, 1, 1, O_BLT);
    repeat (7) cyc(0, 1, 1, O_BLT);
    cyc(1, 1, 1, O_YLD);
    repeat (3) cyc(1, 1, 1, O_YLD);
    cyc(1, 0, 1, O_TRN);
    cyc(1, 0, 1, O_DSP);
    repeat (4) cyc(1, 1, 1, O_DSP);
    cyc(0, 1, 1, O_TRN);
    cyc(0, 1, 1, O_BLT);
    cyc(0, 1, 1, O_BLT);
    cyc(0, 0, 1, O_TRN);
    cyc(0, 0, 1, O_CPU);
    cyc(0, 0, 0, O_CPU);

    // DSP withdraws during yield; blitter still resumes from suspend
    tag = "yield_dsp_drop"; step_no = 0;
    cyc(0, 1, 0, O_HLD);
    cyc(0, 1, 1, O_BLT);
    cyc(1, 1, 1, O_YLD);
    cyc(0, 1, 1, O_YLD);
    cyc(0, 1, 1, O_YLD);
    cyc(0, 0, 1, O_TRN);
    cyc(0, 1, 1, O_BLT);
    cyc(0, 0, 1, O_TRN);
    cyc(0, 0, 1, O_CPU);
    cyc(0, 0, 0, O_CPU);

    // Simultaneous requests: DSP first, blitter only after a CPU tenure
    tag = "simultaneous"; step_no = 0;
    cyc(1, 1, 0, O_HLD);
    cyc(1, 1, 1, O_DSP);
    repeat (2) cyc(1, 1, 1, O_DSP);
    cyc(0, 1, 1, O_TRN);
    cyc(0, 1, 1, O_CPU);
    cyc(0, 1, 1, O_CPU);
    cyc(0, 1, 0, O_HLD);
    cyc(0, 1, 1, O_BLT);
    cyc(0, 0, 1, O_TRN);
    cyc(0, 0, 1, O_CPU);
    cyc(0, 0, 0, O_CPU);

    // TURN_CYCLES=3 instance, and HLDA held high blocking a new HOLD
    apply_reset();
    use3 = 1'b1;
    tag = "turn3"; step_no = 0;
    trn_hi = 0;
    cyc(1, 0, 0, O_HLD);
    cyc(1, 0, 1, O_DSP);
    cyc(0, 0, 1, O_TRN);
    cyc(0, 0, 1, O_TRN);
    cyc(0, 0, 1, O_TRN);
    cyc(0, 0, 1, O_CPU);
    n_cmp++;
    assert (trn_hi == 3) else begin
      n_err++;
      $error("FAIL turn3_len obs=%0d exp=3", trn_hi);
    end
    cyc(1, 0, 1, O_CPU);
    cyc(1, 0, 1, O_CPU);
    cyc(1, 0, 0, O_HLD);
    cyc(1, 0, 1, O_DSP);
    cyc(0, 0, 1, O_TRN);
    cyc(0, 0, 1, O_TRN);
    cyc(0, 0, 1, O_TRN);
    cyc(0, 0, 1, O_CPU);
    cyc(0, 0, 0, O_CPU);

    // Asynchronous reset in the middle of S_YIELD
    apply_reset();
    use3 = 1'b0;
    tag = "reset_yield"; step_no = 0;
    cyc(0, 1, 0, O_HLD);
    cyc(0, 1, 1, O_BLT);
    cyc(1, 1, 1, O_YLD);
    cyc(1, 1, 1, O_YLD);
    #2;
    dsp = 1'b0; blt = 1'b0; hlda = 1'b0;
    rst_l = 1'b0;
    #1;
    exp_q.push_back(O_CPU);
    check_out();
    n_cmp++;
    assert (st1 === S_CPU) else begin
      n_err++;
      $error("FAIL reset_yield_state obs=%0d exp=%0d", st1, S_CPU);
    end
    @(posedge clk);
    #1 rst_l = 1'b1;
    tag = "after_reset"; step_no = 0;
    cyc(0, 1, 0, O_HLD);
    cyc(0, 1, 1, O_BLT);
    cyc(0, 0, 1, O_TRN);
    cyc(0, 0, 1, O_CPU);
    cyc(1, 0, 0, O_HLD);
    cyc(1, 0, 1, O_DSP);
    cyc(0, 0, 1, O_TRN);
    cyc(0, 0, 1, O_CPU);
    cyc(0, 0, 0, O_CPU);

    if (exp_q.size() != 0) begin
      n_err++;
      $error("FAIL leftover_expectations obs=%0d exp=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
